tdm_frame_converter: RTL and testbench

//  Parametrised ST-BUS style TDM <-> serial CPU link converter, successor to the single-line c4 pass-through.

---
 rtl/tdm_conv_pkg.sv | 17 +
 rtl/stm_clk_sync.sv | 45 ++++
 rtl/tdm_frame_converter.sv | 175 +++++++++++++++++
 tb/tb_tdm_frame_converter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_conv_pkg.sv
// Shared geometry for the TDM frame converter: default frame shape and derived widths.
package tdm_conv_pkg;

    localparam int SLOTS_DEF      = 32;
    localparam int SLOT_BITS_DEF  = 8;
    localparam int C4_PER_BIT_DEF = 2;

    function automatic int calc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FRAME_BITS = SLOTS_DEF * SLOT_BITS_DEF;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam int DIV_W      = calc_w(C4_PER_BIT_DEF);
    localparam int PTR_W      = BIT_CNT_W;

endpackage

// File: rtl/stm_clk_sync.sv
// Brings the CPU serial clock and data into the c4 domain and flags each rising clock edge.
module stm_clk_sync (
    input  logic c4,
    input  logic reset,
    input  logic clk_in,
    input  logic data_in,
    output logic edge_pulse,
    output logic data_out
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic edge_q, edge_d;
    logic data1_q, data1_d;
    logic data2_q, data2_d;

    // Data rides alongside the clock so data_out is the value present when the edge was seen.
    always_comb begin
        sync1_d = clk_in;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        data1_d = data_in;
        data2_d = data1_q;
    end

    always_ff @(posedge c4) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            data1_q <= 1'b0;
            data2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end

    assign edge_pulse = sync2_q & ~edge_q;
    assign data_out   = data2_q;

endmodule

// File: rtl/tdm_frame_converter.sv
// ST-BUS style TDM trunk <-> slow serial CPU link: double-buffered rx frame store,
// CPU-staged tx frame, per-frame interrupt and overrun flag.
module tdm_frame_converter
    import tdm_conv_pkg::*;
#(
    parameter int SLOTS      = SLOTS_DEF,
    parameter int SLOT_BITS  = SLOT_BITS_DEF,
    parameter int C4_PER_BIT = C4_PER_BIT_DEF
) (
    input  logic c4,
    input  logic reset,
    input  logic f0,
    input  logic data_from_dt,
    output logic data_to_dt,
    input  logic clk_from_stm,
    input  logic data_from_stm,
    output logic data_to_stm,
    input  logic reset_in_rg,
    input  logic reset_out_rg,
    output logic cpu_int,
    output logic overrun
);

    // Default geometry takes the package widths; other sizes derive their own.
    localparam int FB = SLOTS * SLOT_BITS;
    localparam int CW = (FB == FRAME_BITS) ? BIT_CNT_W : calc_w(FB);
    localparam int PW = (FB == FRAME_BITS) ? PTR_W : CW;
    localparam int DW = (C4_PER_BIT == C4_PER_BIT_DEF) ? DIV_W : calc_w(C4_PER_BIT);
    localparam logic [CW-1:0] LAST_BIT = CW'(FB - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FB - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(C4_PER_BIT - 1);

    logic          f0_prev_q, f0_prev_d;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [FB-1:0] rx_bank_q [2];
    logic [FB-1:0] rx_bank_d [2];
    logic          bank_sel_q, bank_sel_d;
    logic [FB-1:0] tx_staging_q, tx_staging_d;
    logic [FB-1:0] tx_active_q, tx_active_d;
    logic          commit_pending_q, commit_pending_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          data_to_dt_q, data_to_dt_d;
    logic          data_to_stm_q, data_to_stm_d;
    logic          cpu_int_q, cpu_int_d;
    logic          overrun_q, overrun_d;

    logic          f0_fall, sample_en, frame_end, frame_start, load_tx;
    logic          cpu_edge, cpu_data, cpu_act, cpu_bank;
    logic [FB-1:0] tx_src;

    stm_clk_sync u_sync (
        .c4        (c4),
        .reset     (reset),
        .clk_in    (clk_from_stm),
        .data_in   (data_from_stm),
        .edge_pulse(cpu_edge),
        .data_out  (cpu_data)
    );

    always_comb begin
        f0_fall     = !f0 && f0_prev_q;
        sample_en   = !f0_fall && (div_q == LAST_DIV);
        frame_end   = sample_en && (bit_cnt_q == LAST_BIT);
        frame_start = !f0_fall && (div_q == '0) && (bit_cnt_q == '0);
        load_tx     = frame_start && commit_pending_q;
        cpu_act     = cpu_edge && !reset_in_rg && !reset_out_rg;

        f0_prev_d = f0;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        if (f0_fall) begin
            div_d     = '0;
            bit_cnt_d = '0;
        end else begin
            div_d = (div_q == LAST_DIV) ? '0 : div_q + DW'(1);
            if (sample_en) begin
                bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CW'(1);
            end
        end

        // A pending commit is swapped in on the same edge that shifts out bit 0.
        tx_src       = load_tx ? tx_staging_q : tx_active_q;
        tx_active_d  = tx_src;
        data_to_dt_d = data_to_dt_q;
        if (!f0_fall && (div_q == '0)) begin
            data_to_dt_d = tx_src[bit_cnt_q];
        end

        commit_pending_d = load_tx ? 1'b0 : commit_pending_q;
        tx_staging_d     = tx_staging_q;
        wr_ptr_d         = wr_ptr_q;
        if (reset_out_rg) begin
            commit_pending_d = 1'b1;
            wr_ptr_d         = '0;
        end else if (cpu_act) begin
            tx_staging_d[wr_ptr_q] = cpu_data;
            if (wr_ptr_q != LAST_PTR) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
        end

        rx_bank_d = rx_bank_q;
        if (sample_en) begin
            rx_bank_d[bank_sel_q][bit_cnt_q] = data_from_dt;
        end
        bank_sel_d = frame_end ? ~bank_sel_q : bank_sel_q;
        cpu_bank   = ~bank_sel_d;

        cpu_int_d = cpu_int_q;
        if (reset_in_rg) begin
            cpu_int_d = 1'b0;
        end
        if (frame_end) begin
            cpu_int_d = 1'b1;
        end
        overrun_d = overrun_q | (frame_end && cpu_int_q && !reset_in_rg);

        // Bit 0 of the CPU bank is never being written while it is read here.
        rd_ptr_d      = rd_ptr_q;
        data_to_stm_d = data_to_stm_q;
        if (frame_end || reset_in_rg) begin
            rd_ptr_d      = '0;
            data_to_stm_d = rx_bank_q[cpu_bank][0];
        end else if (cpu_act) begin
            if (rd_ptr_q != LAST_PTR) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            data_to_stm_d = rx_bank_q[cpu_bank][rd_ptr_d];
        end
    end

    always_ff @(posedge c4) begin
        if (reset) begin
            f0_prev_q        <= 1'b1;
            div_q            <= '0;
            bit_cnt_q        <= '0;
            rx_bank_q[0]     <= '0;
            rx_bank_q[1]     <= '0;
            bank_sel_q       <= 1'b0;
            tx_staging_q     <= '0;
            tx_active_q      <= '0;
            commit_pending_q <= 1'b0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            data_to_dt_q     <= 1'b1;
            data_to_stm_q    <= 1'b0;
            cpu_int_q        <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            f0_prev_q        <= f0_prev_d;
            div_q            <= div_d;
            bit_cnt_q        <= bit_cnt_d;
            rx_bank_q[0]     <= rx_bank_d[0];
            rx_bank_q[1]     <= rx_bank_d[1];
            bank_sel_q       <= bank_sel_d;
            tx_staging_q     <= tx_staging_d;
            tx_active_q      <= tx_active_d;
            commit_pending_q <= commit_pending_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            data_to_dt_q     <= data_to_dt_d;
            data_to_stm_q    <= data_to_stm_d;
            cpu_int_q        <= cpu_int_d;
            overrun_q        <= overrun_d;
        end
    end

    assign data_to_dt  = data_to_dt_q;
    assign data_to_stm = data_to_stm_q;
    assign cpu_int     = cpu_int_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_tdm_frame_converter.sv
// Directed bench for tdm_frame_converter: rx frame capture and CPU readback, tx commit,
// overrun, mid-frame realignment, reset and acknowledge/frame-end collision.
module tb_tdm_frame_converter;
    import tdm_conv_pkg::*;

    localparam int FB = FRAME_BITS;

    logic c4 = 1'b0;
    logic reset, f0, data_from_dt, clk_from_stm, data_from_stm, reset_in_rg, reset_out_rg;
    logic data_to_dt, data_to_stm, cpu_int, overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit keep_realign = 1'b0;
    logic stm_q[$];
    logic dt_q[$];
    logic last_bit;

    always #5 c4 = ~c4;

    tdm_frame_converter dut (
        .c4           (c4),
        .reset        (reset),
        .f0           (f0),
        .data_from_dt (data_from_dt),
        .data_to_dt   (data_to_dt),
        .clk_from_stm (clk_from_stm),
        .data_from_stm(data_from_stm),
        .data_to_stm  (data_to_stm),
        .reset_in_rg  (reset_in_rg),
        .reset_out_rg (reset_out_rg),
        .cpu_int      (cpu_int),
        .overrun      (overrun)
    );

    // Frame bit k of a pattern: slot value is key (optionally xor slot index), MSB first.
    function automatic logic pat_bit(input logic [7:0] key, input bit per_slot, input int k);
        logic [7:0] slot;
        slot = per_slot ? (key ^ 8'(k / SLOT_BITS_DEF)) : key;
        return slot[SLOT_BITS_DEF - 1 - (k % SLOT_BITS_DEF)];
    endfunction

    // Periodic f0 pulses keep the rx side from ever completing a frame during slow CPU reads.
    task automatic cycle();
        @(posedge c4);
        #1;
        cyc++;
        if (keep_realign) f0 = (cyc % 100 == 0) ? 1'b0 : 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One TDM bit: first edge updates data_to_dt, second edge samples data_from_dt.
    task automatic applyStimulus(input logic din, input bit chk_dt);
        logic e;
        data_from_dt = din;
        cycle();
        if (chk_dt) begin
            e = dt_q.pop_front();
            checkOutput("data_to_dt", data_to_dt, e);
        end
        cycle();
    endtask

    task automatic realign();
        f0 = 1'b1;
        cycle();
        f0 = 1'b0;
        cycle();
        f0 = 1'b1;
    endtask

    task automatic cpu_edge(input logic wdata);
        data_from_stm = wdata;
        clk_from_stm = 1'b1;
        repeat (4) cycle();
        clk_from_stm = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic read_bits(input int n, input string tag, input bit write_a5);
        keep_realign = 1'b1;
        for (int i = 0; i < n; i++) begin
            last_bit = stm_q.pop_front();
            checkOutput(tag, data_to_stm, last_bit);
            cpu_edge(write_a5 ? pat_bit(8'hA5, 1'b0, i) : 1'b0);
        end
        keep_realign = 1'b0;
        f0 = 1'b1;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; f0 = 1'b1; data_from_dt = 1'b0; clk_from_stm = 1'b0;
        data_from_stm = 1'b0; reset_in_rg = 1'b0; reset_out_rg = 1'b0;
        repeat (3) cycle();
        $display("[TB] reset values");
        checkOutput("rst_data_to_dt", data_to_dt, 1'b1);
        checkOutput("rst_data_to_stm", data_to_stm, 1'b0);
        checkOutput("rst_cpu_int", cpu_int, 1'b0);
        checkOutput("rst_overrun", overrun, 1'b0);
        reset = 1'b0;
        cycle();

        $display("[TB] receive frame slot n = n");
        realign();
        for (int k = 0; k < FB; k++) begin
            stm_q.push_back(pat_bit(8'h00, 1'b1, k));
            applyStimulus(pat_bit(8'h00, 1'b1, k), 1'b0);
            checkOutput("t1_cpu_int", cpu_int, (k == FB - 1));
        end

        $display("[TB] CPU readback with A5 writes");
        read_bits(FB, "t2_read", 1'b1);
        cpu_edge(1'b1);
        checkOutput("t2_read_saturate", data_to_stm, last_bit);
        checkOutput("t2_no_overrun", overrun, 1'b0);

        $display("[TB] commit A5 mid-frame, two rx frames with cpu_int left set");
        reset_in_rg = 1'b1;
        cycle();
        reset_in_rg = 1'b0;
        checkOutput("t3_ack_cpu_int", cpu_int, 1'b0);
        for (int k = 0; k < FB; k++) dt_q.push_back(1'b0);
        for (int k = 0; k < FB; k++) dt_q.push_back(pat_bit(8'hA5, 1'b0, k));
        realign();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FB; k++) begin
                reset_out_rg = (f == 0 && k == 10);
                if (f == 1) stm_q.push_back(pat_bit(8'h5A, 1'b1, k));
                applyStimulus(pat_bit((f == 0) ? 8'hC5 : 8'h5A, 1'b1, k), 1'b1);
                checkOutput("t3_cpu_int", cpu_int, (f == 1) || (k == FB - 1));
            end
            checkOutput("t4_overrun", overrun, (f == 1));
        end
        reset_out_rg = 1'b0;

        $display("[TB] acknowledge after overrun, read second frame");
        reset_in_rg = 1'b1;
        cycle();
        reset_in_rg = 1'b0;
        checkOutput("t4_ack_cpu_int", cpu_int, 1'b0);
        checkOutput("t4_overrun_sticky", overrun, 1'b1);
        read_bits(16, "t4_read", 1'b0);
        stm_q.delete();

        $display("[TB] f0 at bit 100 discards partial frame");
        realign();
        for (int k = 0; k < 100; k++) applyStimulus(pat_bit(8'h3C, 1'b1, k), 1'b0);
        f0 = 1'b0;
        cycle();
        f0 = 1'b1;
        for (int k = 0; k < FB; k++) begin
            stm_q.push_back(pat_bit(8'hC3, 1'b1, k));
            applyStimulus(pat_bit(8'hC3, 1'b1, k), 1'b0);
            checkOutput("t5_cpu_int", cpu_int, (k == FB - 1));
        end
        read_bits(8, "t5_read", 1'b0);
        stm_q.delete();
        checkOutput("t5_overrun_sticky", overrun, 1'b1);

        $display("[TB] reset at bit 50");
        realign();
        for (int k = 0; k < 50; k++) applyStimulus(1'b0, 1'b0);
        reset = 1'b1;
        cycle();
        checkOutput("t6_data_to_dt", data_to_dt, 1'b1);
        checkOutput("t6_data_to_stm", data_to_stm, 1'b0);
        checkOutput("t6_cpu_int", cpu_int, 1'b0);
        checkOutput("t6_overrun", overrun, 1'b0);
        reset = 1'b0;

        $display("[TB] reset_in_rg coincident with frame end");
        realign();
        for (int k = 0; k < FB; k++) begin
            reset_in_rg = (k == FB - 1);
            applyStimulus(pat_bit(8'hC5, 1'b1, k), 1'b0);
        end
        reset_in_rg = 1'b0;
        checkOutput("t6_collide_cpu_int", cpu_int, 1'b1);
        checkOutput("t6_collide_stm_bit0", data_to_stm, pat_bit(8'hC5, 1'b1, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
